ph_reg3: RTL and testbench

Register 3 FIFO in the parasite-to-host direction: a two-byte buffer for high-speed 16-bit block transfers, written by the parasite and read by the host. It mirrors the host-to-parasite register 3 path. Two behaviours are selected by the V flag:
- One-byte mode: the block behaves as a single latch.
- Two-byte mode: data is signalled only when both bytes are present, and "full" persists until both bytes are removed.

---
 rtl/tube_pkg.sv | 10 +
 rtl/ph_reg3_if.sv | 25 ++
 rtl/ph_reg3_flag.sv | 31 +++
 rtl/ph_reg3.sv | 83 ++++++++
 tb/tb_ph_reg3.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/tube_pkg.sv
// rtl/tube_pkg.sv - shared tube register constants
package tube_pkg;

    localparam int TUBE_DATA_W = 8;

    // Slot indices into the two-byte register 3 buffer
    localparam logic SLOT0 = 1'b0;
    localparam logic SLOT1 = 1'b1;

endpackage

// File: rtl/ph_reg3_if.sv
// rtl/ph_reg3_if.sv - host/parasite access signals for register 3 (parasite to host)
interface ph_reg3_if;
    import tube_pkg::*;

    logic                   h_selectData;
    logic                   h_rdnw;
    logic [TUBE_DATA_W-1:0] h_data;
    logic                   h_data_available;
    logic                   p_selectData;
    logic [TUBE_DATA_W-1:0] p_data;
    logic                   one_byte_mode;
    logic                   p_full;
    logic                   p_empty;

    modport master (
        output h_selectData, h_rdnw, p_selectData, p_data, one_byte_mode,
        input  h_data, h_data_available, p_full, p_empty
    );

    modport slave (
        input  h_selectData, h_rdnw, p_selectData, p_data, one_byte_mode,
        output h_data, h_data_available, p_full, p_empty
    );

endinterface

// File: rtl/ph_reg3_flag.sv
// rtl/ph_reg3_flag.sv - toggle-pair flag cell, set from the parasite edge, cleared from the host edge
module ph_flag_m (
    input  logic h_rst_b,
    input  logic p_wrstb_b,
    input  logic h_phi2,
    input  logic set_en,
    input  logic clr_en,
    output logic flag
);

    logic set_tgl;
    logic clr_tgl;

    // Each domain only ever flips its own toggle, so no event is lost across domains
    always_ff @(posedge p_wrstb_b or negedge h_rst_b) begin
        if (!h_rst_b)
            set_tgl <= 1'b0;
        else if (set_en)
            set_tgl <= ~set_tgl;
    end

    always_ff @(negedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b)
            clr_tgl <= 1'b0;
        else if (clr_en)
            clr_tgl <= ~clr_tgl;
    end

    assign flag = set_tgl ^ clr_tgl;

endmodule

// File: rtl/ph_reg3.sv
// rtl/ph_reg3.sv - register 3 parasite-to-host two-byte FIFO
module ph_reg3
    import tube_pkg::*;
(
    input  logic       h_phi2,
    input  logic       h_rst_b,
    input  logic       p_wrstb_b,
    ph_reg3_if.slave   bus
);

    logic [TUBE_DATA_W-1:0] slot_q [0:1];
    logic                   f0;
    logic                   f1;
    logic                   p_wr;
    logic                   h_rd;
    logic                   set0_en;
    logic                   set1_en;
    logic                   clr0_en;
    logic                   clr1_en;
    logic                   read_slot1;

    assign p_wr = bus.p_selectData;
    assign h_rd = bus.h_selectData & bus.h_rdnw;

    // One-byte mode keeps overwriting byte0; two-byte mode fills slot0 then slot1, then blocks
    always_comb begin
        set0_en = 1'b0;
        set1_en = 1'b0;
        clr0_en = 1'b0;
        clr1_en = 1'b0;
        if (p_wr) begin
            if (bus.one_byte_mode)
                set0_en = !f0;
            else begin
                set0_en = !f0 && !f1;
                set1_en = f0 && !f1;
            end
        end
        if (h_rd) begin
            clr0_en = f0;
            clr1_en = !bus.one_byte_mode && !f0 && f1;
        end
    end

    always_ff @(posedge p_wrstb_b or negedge h_rst_b) begin
        if (!h_rst_b) begin
            slot_q[SLOT0] <= '0;
            slot_q[SLOT1] <= '0;
        end else if (p_wr) begin
            if (bus.one_byte_mode || set0_en)
                slot_q[SLOT0] <= bus.p_data;
            else if (set1_en)
                slot_q[SLOT1] <= bus.p_data;
        end
    end

    ph_flag_m u_flag0 (
        .h_rst_b   (h_rst_b),
        .p_wrstb_b (p_wrstb_b),
        .h_phi2    (h_phi2),
        .set_en    (set0_en),
        .clr_en    (clr0_en),
        .flag      (f0)
    );

    ph_flag_m u_flag1 (
        .h_rst_b   (h_rst_b),
        .p_wrstb_b (p_wrstb_b),
        .h_phi2    (h_phi2),
        .set_en    (set1_en),
        .clr_en    (clr1_en),
        .flag      (f1)
    );

    // Once byte0 has been taken in two-byte mode the host sees byte1 at the same address
    assign read_slot1 = !bus.one_byte_mode && !f0 && f1;

    assign bus.h_data           = read_slot1 ? slot_q[SLOT1] : slot_q[SLOT0];
    assign bus.h_data_available = bus.one_byte_mode ? f0 : f1;
    assign bus.p_full           = bus.one_byte_mode ? f0 : f1;
    assign bus.p_empty          = !f0 && !f1;

endmodule

// File: tb/tb_ph_reg3.sv
// tb/tb_ph_reg3.sv - scoreboard bench for ph_reg3
`timescale 1ns/100ps
module tb_ph_reg3;

    logic h_phi2;
    logic h_rst_b;
    logic p_wrstb_b;

    ph_reg3_if bus_if ();

    ph_reg3 dut (
        .h_phi2    (h_phi2),
        .h_rst_b   (h_rst_b),
        .p_wrstb_b (p_wrstb_b),
        .bus       (bus_if.slave)
    );

    int         n_vec;
    int         n_err;
    logic [7:0] exp_q [$];
    logic       m_full;

    initial h_phi2 = 1'b0;
    always #10 h_phi2 = ~h_phi2;

    task automatic chk_status(input string tag);
        logic exp_empty;
        exp_empty = (exp_q.size() == 0);
        n_vec++;
        if (bus_if.h_data_available !== m_full) begin
            n_err++;
            $display("FAIL %s h_data_available got %b want %b", tag, bus_if.h_data_available, m_full);
        end
        n_vec++;
        if (bus_if.p_full !== m_full) begin
            n_err++;
            $display("FAIL %s p_full got %b want %b", tag, bus_if.p_full, m_full);
        end
        n_vec++;
        if (bus_if.p_empty !== exp_empty) begin
            n_err++;
            $display("FAIL %s p_empty got %b want %b", tag, bus_if.p_empty, exp_empty);
        end
    endtask

    task automatic model_write(input logic [7:0] d);
        if (bus_if.one_byte_mode) begin
            if (exp_q.size() == 0) exp_q.push_back(d);
            else exp_q[0] = d;
            m_full = 1'b1;
        end else if (!m_full) begin
            exp_q.push_back(d);
            if (exp_q.size() == 2) m_full = 1'b1;
        end
    endtask

    task automatic p_write(input logic [7:0] d);
        @(posedge h_phi2);
        bus_if.p_selectData = 1'b1;
        bus_if.p_data       = d;
        #2 p_wrstb_b = 1'b0;
        #5 p_wrstb_b = 1'b1;
        model_write(d);
        #1 bus_if.p_selectData = 1'b0;
        chk_status($sformatf("write_%02h", d));
    endtask

    task automatic h_read(input string tag);
        logic [7:0] exp_d;
        logic       have;
        @(posedge h_phi2);
        #1;
        bus_if.h_selectData = 1'b1;
        bus_if.h_rdnw       = 1'b1;
        #4;
        have = (exp_q.size() > 0);
        if (have) begin
            exp_d = exp_q.pop_front();
            n_vec++;
            if (bus_if.h_data !== exp_d) begin
                n_err++;
                $display("FAIL %s h_data got %02h want %02h", tag, bus_if.h_data, exp_d);
            end
        end
        @(negedge h_phi2);
        #1;
        bus_if.h_selectData = 1'b0;
        bus_if.h_rdnw       = 1'b0;
        if (bus_if.one_byte_mode || exp_q.size() == 0) m_full = 1'b0;
        chk_status({tag, "_after"});
    endtask

    task automatic do_reset();
        @(posedge h_phi2);
        #3 h_rst_b = 1'b0;
        exp_q.delete();
        m_full = 1'b0;
        #4 h_rst_b = 1'b1;
    endtask

    task automatic test_reset();
        n_vec++;
        if (bus_if.h_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_h_data got %02h want 00", bus_if.h_data);
        end
        chk_status("reset_initial");
        bus_if.one_byte_mode = 1'b0;
        p_write(8'hC3);
        p_write(8'h3C);
        @(negedge h_phi2);
        #4 h_rst_b = 1'b0;
        exp_q.delete();
        m_full = 1'b0;
        #1;
        n_vec++;
        if (bus_if.h_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid h_data got %02h want 00", bus_if.h_data);
        end
        chk_status("reset_mid");
        #3 h_rst_b = 1'b1;
    endtask

    task automatic test_two_byte();
        bus_if.one_byte_mode = 1'b0;
        p_write(8'h12);
        p_write(8'h34);
        h_read("two_rd0");
        h_read("two_rd1");
    endtask

    task automatic test_overflow();
        bus_if.one_byte_mode = 1'b0;
        p_write(8'h12);
        p_write(8'h34);
        p_write(8'h56);
        h_read("ovf_rd0");
        p_write(8'h78);
        h_read("ovf_rd1");
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL ovf_leftover got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_one_byte();
        do_reset();
        bus_if.one_byte_mode = 1'b1;
        p_write(8'hA5);
        p_write(8'h5A);
        h_read("one_rd");
        n_vec++;
        if (bus_if.h_data_available !== 1'b0) begin
            n_err++;
            $display("FAIL one_avail got %b want 0", bus_if.h_data_available);
        end
    endtask

    task automatic test_read_empty();
        do_reset();
        bus_if.one_byte_mode = 1'b0;
        for (int i = 0; i < 3; i++) h_read($sformatf("empty_rd%0d", i));
        p_write(8'h9E);
        n_vec++;
        if (bus_if.h_data_available !== 1'b0) begin
            n_err++;
            $display("FAIL empty_half avail got %b want 0", bus_if.h_data_available);
        end
        p_write(8'hE9);
        h_read("empty_pair0");
        h_read("empty_pair1");
    endtask

    task automatic test_concurrent();
        do_reset();
        bus_if.one_byte_mode = 1'b0;
        p_write(8'h77);
        @(posedge h_phi2);
        #1;
        bus_if.h_selectData = 1'b1;
        bus_if.h_rdnw       = 1'b1;
        bus_if.p_selectData = 1'b1;
        bus_if.p_data       = 8'h88;
        p_wrstb_b           = 1'b0;
        #4;
        n_vec++;
        if (bus_if.h_data !== 8'h77) begin
            n_err++;
            $display("FAIL conc_byte0 got %02h want 77", bus_if.h_data);
        end
        void'(exp_q.pop_front());
        #4.5 p_wrstb_b = 1'b1;
        exp_q.push_back(8'h88);
        @(negedge h_phi2);
        #1;
        bus_if.h_selectData = 1'b0;
        bus_if.h_rdnw       = 1'b0;
        bus_if.p_selectData = 1'b0;
        m_full = 1'b1;
        chk_status("conc_after");
        h_read("conc_rd1");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_full = 1'b0;
        p_wrstb_b = 1'b1;
        bus_if.h_selectData  = 1'b0;
        bus_if.h_rdnw        = 1'b0;
        bus_if.p_selectData  = 1'b0;
        bus_if.p_data        = 8'h00;
        bus_if.one_byte_mode = 1'b0;
        h_rst_b = 1'b0;
        #15 h_rst_b = 1'b1;
        #2;
        test_reset();
        test_two_byte();
        test_overflow();
        test_one_byte();
        test_read_empty();
        test_concurrent();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
